// File: rtl/gcode_pkg.sv
// Shared G-code command definitions: opcode encodings, command word layout and coordinate width.
// Imported by both the command source and the controller-side receiver so encodings cannot drift.
package gcode_pkg;

    localparam int COORD_W = 14;

    typedef enum logic [3:0] {
        OP_G00 = 4'd0,
        OP_G01 = 4'd1,
        OP_G20 = 4'd2,
        OP_G21 = 4'd3,
        OP_G90 = 4'd4,
        OP_G91 = 4'd5,
        OP_M2  = 4'd6,
        OP_M6  = 4'd7,
        OP_M72 = 4'd8
    } op_e;

    // Memory word layout: {opcode, x, y}, opcode in the top nibble.
    typedef struct packed {
        op_e                cmd;
        logic [COORD_W-1:0] x_value;
        logic [COORD_W-1:0] y_value;
    } cmd_t;

    // Encodings 9..15 are reserved and treated as illegal.
    function automatic logic op_legal(input logic [3:0] op);
        return op <= 4'd8;
    endfunction

endpackage

// File: rtl/gcode_command_source_if.sv
// Command handover channel between the program walker (master) and the controller receiver (slave).
// The receiver latches on the rising edge of memory_ready & controller_ready.
interface gcode_command_source_if #(
    parameter int COORD_W = gcode_pkg::COORD_W
);
    logic [3:0]         cmd_code;
    logic [COORD_W-1:0] x_value;
    logic [COORD_W-1:0] y_value;
    logic               memory_ready;
    logic               controller_ready;

    modport master (
        output cmd_code, x_value, y_value, memory_ready,
        input  controller_ready
    );

    modport slave (
        input  cmd_code, x_value, y_value, memory_ready,
        output controller_ready
    );
endinterface

// File: rtl/gcode_command_source.sv
// Walks a G-code program in a synchronous-read command memory and hands one command at a time
// to the controller. Stops on M2, on running past the last program slot, or on reset.
module gcode_command_source
    import gcode_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int PROG_LEN = 256,
    parameter int COORD_W  = gcode_pkg::COORD_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [4+2*COORD_W-1:0] mem_data,
    gcode_command_source_if.master cmd_if,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 overrun,
    output logic [ADDR_W:0]      cmd_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PRESENT,
        S_DONE
    } state_e;

    state_e state, state_nxt;

    logic [3:0]         rd_op;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic [3:0]         cmd_code_q;
    logic [COORD_W-1:0] x_value_q;
    logic [COORD_W-1:0] y_value_q;

    logic last_slot;
    logic launch;
    logic take;
    logic skip;
    logic handover;
    logic advance;

    assign rd_op = mem_data[4+2*COORD_W-1 -: 4];
    assign rd_x  = mem_data[2*COORD_W-1 -: COORD_W];
    assign rd_y  = mem_data[COORD_W-1:0];

    assign last_slot = (mem_addr == ADDR_W'(PROG_LEN - 1));
    assign launch    = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign take      = (state == S_LOAD) && op_legal(rd_op) && (rd_op != OP_M2);
    assign skip      = (state == S_LOAD) && !op_legal(rd_op);
    assign handover  = (state == S_PRESENT) && cmd_if.controller_ready;
    assign advance   = skip || handover;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_FETCH;
            S_FETCH:        state_nxt = S_LOAD;
            S_LOAD: begin
                if (rd_op == OP_M2)       state_nxt = S_DONE;
                else if (!op_legal(rd_op)) state_nxt = last_slot ? S_DONE : S_FETCH;
                else                       state_nxt = S_PRESENT;
            end
            S_PRESENT: if (cmd_if.controller_ready) state_nxt = last_slot ? S_DONE : S_FETCH;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // memory_ready is a pure decode of the state register, so it drops on the same edge that leaves PRESENT.
    always_comb begin
        cmd_if.memory_ready = (state == S_PRESENT);
        busy                = (state == S_FETCH) || (state == S_LOAD) || (state == S_PRESENT);
        done                = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr   <= '0;
            cmd_count  <= '0;
            error      <= 1'b0;
            overrun    <= 1'b0;
            cmd_code_q <= '0;
            x_value_q  <= '0;
            y_value_q  <= '0;
        end else begin
            if (launch) begin
                mem_addr  <= '0;
                cmd_count <= '0;
                error     <= 1'b0;
                overrun   <= 1'b0;
            end
            if (take) begin
                cmd_code_q <= rd_op;
                x_value_q  <= rd_x;
                y_value_q  <= rd_y;
            end
            if (skip) error <= 1'b1;
            if (advance) begin
                if (last_slot) overrun  <= 1'b1;
                else           mem_addr <= mem_addr + ADDR_W'(1);
            end
            if (handover && (cmd_count != {(ADDR_W+1){1'b1}}))
                cmd_count <= cmd_count + (ADDR_W+1)'(1);
        end
    end

    assign cmd_if.cmd_code = cmd_code_q;
    assign cmd_if.x_value  = x_value_q;
    assign cmd_if.y_value  = y_value_q;

endmodule

// File: tb/tb_gcode_command_source.sv
// Directed bench for gcode_command_source: a 256-slot instance and a 4-slot instance,
// each fed by a 1-cycle synchronous ROM model.
module tb_gcode_command_source;
    import gcode_pkg::*;

    localparam int ADDR_W = 8;
    localparam int W      = 4 + 2*COORD_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Main instance (PROG_LEN = 256)
    logic              start;
    logic [ADDR_W-1:0] mem_addr;
    logic [W-1:0]      mem_data;
    logic              busy, done, error, overrun;
    logic [ADDR_W:0]   cmd_count;
    logic [W-1:0]      rom [0:255];

    gcode_command_source_if #(.COORD_W(COORD_W)) cmd_if ();

    gcode_command_source #(.ADDR_W(ADDR_W), .PROG_LEN(256), .COORD_W(COORD_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .mem_addr(mem_addr), .mem_data(mem_data), .cmd_if(cmd_if),
        .busy(busy), .done(done), .error(error), .overrun(overrun), .cmd_count(cmd_count)
    );

    always @(posedge clk) mem_data <= rom[mem_addr];

    // Short-program instance (PROG_LEN = 4)
    logic              start4;
    logic [ADDR_W-1:0] mem_addr4;
    logic [W-1:0]      mem_data4;
    logic              busy4, done4, error4, overrun4;
    logic [ADDR_W:0]   cmd_count4;
    logic [W-1:0]      rom4 [0:3];

    gcode_command_source_if #(.COORD_W(COORD_W)) cmd_if4 ();

    gcode_command_source #(.ADDR_W(ADDR_W), .PROG_LEN(4), .COORD_W(COORD_W)) dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .mem_addr(mem_addr4), .mem_data(mem_data4), .cmd_if(cmd_if4),
        .busy(busy4), .done(done4), .error(error4), .overrun(overrun4), .cmd_count(cmd_count4)
    );

    always @(posedge clk) mem_data4 <= rom4[mem_addr4[1:0]];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [3:0] op, input int x, input int y);
        cmd_t c;
        c.cmd     = op_e'(op);
        c.x_value = COORD_W'(x);
        c.y_value = COORD_W'(y);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2);
        for (int i = 0; i < 256; i++) rom[i] = mk(OP_M2, 0, 0);
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
    endtask

    // Runs the main instance until done, counting cycles with memory_ready high.
    task automatic run_to_done(input string tag, output int pulses);
        int n = 0;
        pulses = 0;
        while (!done && n < 200) begin
            if (cmd_if.memory_ready) pulses++;
            tick();
            n++;
        end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int pulses;
        int n;
        reset = 1'b1;
        start = 1'b0;
        start4 = 1'b0;
        cmd_if.controller_ready  = 1'b1;
        cmd_if4.controller_ready = 1'b1;
        load_prog(mk(OP_G01, 100, 200), mk(OP_G00, 5, 7), mk(OP_M2, 0, 0));
        rom4[0] = mk(OP_G01, 1, 1);
        rom4[1] = mk(OP_G90, 0, 0);
        rom4[2] = mk(OP_G00, 2, 2);
        rom4[3] = mk(OP_G21, 0, 0);
        repeat (3) tick();

        // Reset state
        check("rst_addr", mem_addr, 0);
        check("rst_ready", cmd_if.memory_ready, 0);
        check("rst_code", cmd_if.cmd_code, 0);
        check("rst_xy", {cmd_if.x_value, cmd_if.y_value}, 0);
        check("rst_flags", {busy, done, error, overrun}, 0);
        check("rst_count", cmd_count, 0);
        reset = 1'b0;
        tick();

        // Two handovers with controller_ready high: 1-cycle pulses, 3 cycles apart
        pulse_start();
        check("t1_fetch_busy", {busy, cmd_if.memory_ready}, 2'b10);
        tick();
        check("t1_load_ready", cmd_if.memory_ready, 0);
        tick();
        check("t1_p1_ready", cmd_if.memory_ready, 1);
        check("t1_p1_code", cmd_if.cmd_code, 1);
        check("t1_p1_x", cmd_if.x_value, 100);
        check("t1_p1_y", cmd_if.y_value, 200);
        tick();
        check("t1_after_ready", cmd_if.memory_ready, 0);
        check("t1_after_count", cmd_count, 1);
        check("t1_after_hold", cmd_if.cmd_code, 1);
        tick();
        check("t1_gap2_ready", cmd_if.memory_ready, 0);
        tick();
        check("t1_p2_ready", cmd_if.memory_ready, 1);
        check("t1_p2_xy", {cmd_if.cmd_code, cmd_if.x_value, cmd_if.y_value}, {4'd0, 14'd5, 14'd7});
        tick();
        tick();
        tick();
        check("t1_done", {done, busy, cmd_if.memory_ready}, 3'b100);
        check("t1_count", cmd_count, 2);
        check("t1_addr", mem_addr, 2);

        // Receiver stalls for 10 cycles on the first command
        cmd_if.controller_ready = 1'b0;
        pulse_start();
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t2_hold%0d", i),
                  {cmd_if.memory_ready, cmd_if.cmd_code, cmd_if.x_value, cmd_if.y_value},
                  {1'b1, 4'd1, 14'd100, 14'd200});
            tick();
        end
        check("t2_count_stalled", cmd_count, 0);
        cmd_if.controller_ready = 1'b1;
        tick();
        check("t2_handover", {cmd_if.memory_ready, 5'(cmd_count)}, {1'b0, 5'd1});
        run_to_done("t2", pulses);
        check("t2_count", cmd_count, 2);

        // Illegal opcode skipped and flagged
        load_prog(mk(OP_G20, 3, 4), mk(4'd12, 9, 9), mk(OP_M2, 0, 0));
        pulse_start();
        run_to_done("t3", pulses);
        check("t3_error", error, 1);
        check("t3_pulses", pulses, 1);
        check("t3_count", cmd_count, 1);
        check("t3_last_code", cmd_if.cmd_code, 2);
        check("t3_last_xy", {cmd_if.x_value, cmd_if.y_value}, {14'd3, 14'd4});

        // Start from DONE clears error; start while busy is ignored
        load_prog(mk(OP_G01, 100, 200), mk(OP_G00, 5, 7), mk(OP_M2, 0, 0));
        pulse_start();
        check("t4_error_clr", error, 0);
        tick();
        tick();
        tick();
        check("t4_count1", cmd_count, 1);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        check("t4_busy_start_addr", mem_addr, 1);
        check("t4_busy_start_cmd", {cmd_if.memory_ready, cmd_if.cmd_code, cmd_if.x_value},
              {1'b1, 4'd0, 14'd5});
        run_to_done("t4", pulses);
        check("t4_count", cmd_count, 2);

        // Program without M2 runs off the end of a 4-slot program
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        pulses = 0;
        n = 0;
        while (!done4 && n < 100) begin
            if (cmd_if4.memory_ready) pulses++;
            tick();
            n++;
        end
        check("t5_done", done4, 1);
        check("t5_pulses", pulses, 4);
        check("t5_overrun", overrun4, 1);
        check("t5_addr", mem_addr4, 3);
        check("t5_count", cmd_count4, 4);
        check("t5_last", {cmd_if4.cmd_code}, 3);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("t5_rerun_clr", {overrun4, busy4}, 2'b01);

        // Reset in PRESENT with controller_ready low
        cmd_if.controller_ready = 1'b0;
        pulse_start();
        tick();
        tick();
        check("t6_present", cmd_if.memory_ready, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_ready", cmd_if.memory_ready, 0);
        check("t6_outs", {cmd_if.cmd_code, cmd_if.x_value, cmd_if.y_value}, 0);
        check("t6_state", {busy, done, error, overrun, 9'(cmd_count), mem_addr}, 0);
        tick();
        check("t6_idle_hold", {busy, done}, 0);
        cmd_if.controller_ready = 1'b1;
        pulse_start();
        tick();
        tick();
        check("t6_rerun", {cmd_if.memory_ready, cmd_if.cmd_code, cmd_if.x_value, 8'(mem_addr)},
              {1'b1, 4'd1, 14'd100, 8'd0});
        run_to_done("t6", pulses);
        check("t6_count", cmd_count, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gcode_command_source.md
Name: gcode_command_source

Overview:
- Memory-side initiator of the G-code command interface. It walks a program stored in an external synchronous-read command memory and presents one command at a time (opcode, X, Y) with `memory_ready`.
- It waits for `controller_ready` from the controller-interface receiver, which latches on the rising edge of `memory_ready & controller_ready`.
- It stops on M2 (program end), on program overrun, or on reset.

Parameters:
- ADDR_W, 8, command memory address width.
- PROG_LEN, 256, number of valid program slots (≤ 2**ADDR_W).
- COORD_W, 14, width of each X/Y coordinate field.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin execution from address 0; sampled in IDLE or DONE only
- mem_addr  out  ADDR_W  command memory read address (registered)
- mem_data  in  4+2*COORD_W  word read from memory; packing {opcode[3:0], x, y}; valid the cycle after mem_addr is held for one edge
- cmd_code  out  4  opcode presented to the receiver
- x_value  out  COORD_W  X operand presented
- y_value  out  COORD_W  Y operand presented
- memory_ready  out  1  presented command is valid and stable
- controller_ready  in  1  receiver accepts the command
- busy  out  1  high in FETCH/LOAD/PRESENT
- done  out  1  high in DONE
- error  out  1  sticky: illegal opcode seen
- overrun  out  1  sticky: PROG_LEN exhausted without M2
- cmd_count  out  ADDR_W+1  commands handed over since last start

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE.
  - All outputs 0: mem_addr, cmd_code, x_value, y_value, memory_ready, done, error, overrun, cmd_count.
  - Reset mid-PRESENT drops memory_ready at that same edge; no handshake completes on that edge.
- Opcode encoding: G00=0, G01=1, G20=2, G21=3, G90=4, G91=5, M2=6, M6=7, M72=8. Values 9–15 are illegal.
- States: IDLE, FETCH, LOAD, PRESENT, DONE.
- IDLE: on start, set mem_addr=0, cmd_count=0, clear error/overrun → FETCH.
- FETCH: mem_addr held; memory_ready=0 → LOAD.
- LOAD (mem_data valid):
  - Opcode M2 → DONE; not presented; cmd_count unchanged.
  - Illegal opcode → set error; skip the slot via the advance rule.
  - Otherwise register cmd_code, x_value, y_value; memory_ready<=1 → PRESENT.
- PRESENT:
  - Hold memory_ready and all three data outputs stable until an edge with controller_ready=1.
  - At that edge: memory_ready<=0, cmd_count+1, apply the advance rule.
  - If controller_ready is already 1 on entry, transfer occurs at the first PRESENT edge; memory_ready is high exactly 1 cycle.
- Advance rule:
  - If mem_addr==PROG_LEN-1: set overrun → DONE.
  - Else mem_addr+1 → FETCH.
- Gap guarantee: memory_ready is low ≥2 cycles (FETCH, LOAD) between consecutive commands, so the receiver always sees a fresh rising edge.
- DONE: done=1; start re-runs exactly as from IDLE; otherwise hold.
- start while busy is ignored.
- After a handover, cmd_code/x_value/y_value retain their last values; they change only in LOAD.
- Latency: start sampled at edge E → memory_ready=1 after edge E+2. Steady-state throughput is one command per 3 cycles with controller_ready tied high.
- cmd_count saturates at its maximum (unreachable when PROG_LEN ≤ 2**ADDR_W).

Decomposition:
- Shared package `gcode_pkg`: opcode enum with explicit 4-bit encodings, the packed command struct {cmd, x_value, y_value}, and the COORD_W constant. This module and the controller interface receiver both import it, so the encodings never diverge.
- No sub-module: the FSM plus address/count registers form one block.
- The command memory is external; the bench supplies a 1-cycle synchronous ROM model.

Test Plan:
- Program [G01 x=100 y=200, G00 x=5 y=7, M2], controller_ready=1 → two handovers with exact values; memory_ready pulses 1 cycle each, 3 cycles apart; done=1; cmd_count=2; mem_addr=2.
- Same program, controller_ready held 0 for 10 cycles on the first command → memory_ready, cmd_code=1, x_value=100, y_value=200 stable all 10 cycles; handover on the edge controller_ready rises.
- Opcode 12 at address 1 between G20 and M2 → error=1; only G20 presented; cmd_count=1; done=1.
- PROG_LEN=4 with no M2 → 4 handovers, overrun=1, done=1, mem_addr=3.
- Reset asserted in PRESENT with controller_ready=0 → next cycle state IDLE, all outputs 0; subsequent start re-runs from address 0.
- start pulsed while busy → ignored; start pulsed in DONE → error/overrun cleared and the program re-executes.
